lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_if.sv | 38 +++
 rtl/lsu_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if -- request/response/memory bundle for the load-store controller.
//   req_*  : request handshake (valid/ready) carrying we, start addr,
//            len (words-1) and a fill value for write bursts.
//   rsp_*  : one-cycle response strobe with read data, last and error flags.
//   busy   : controller is not idle.
//   mem_*  : single-port data memory strobes, address, write data and
//            combinational read data.
// Modport slave is the controller side; master is the requester/memory side.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [2:0]  req_len;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_last;
  logic        rsp_err;
  logic        busy;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_len, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err, busy,
           mem_read_en, mem_write_en, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_len, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err, busy,
           mem_read_en, mem_write_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- burst load/store controller for a 16-bit word memory.
//   clk : rising-edge clock for all state.
//   rst : asynchronous active-high reset.
//   bus : lsu_ctrl_if.slave -- request in, response out, memory strobes out.
// Read bursts return one registered word per cycle; write bursts store the
// same fill value to 1..8 consecutive words and answer with a single response.
// Requests whose last address falls outside 0..MEM_DEPTH-1 are rejected with
// an error response and never touch the memory.
module lsu_ctrl #(
  parameter int unsigned MEM_DEPTH = 1024
) (
  input logic       clk,
  input logic       rst,
  lsu_ctrl_if.slave bus
);

  localparam logic [16:0] LAST_ADDR = 17'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cur_addr;
  logic [2:0]  r_count;
  logic [15:0] r_fill;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_rdata;
  logic        r_rsp_last;
  logic        r_rsp_err;

  logic        w_accept;
  logic [16:0] w_end_addr;
  logic        w_range_err;
  logic        w_mem_re;
  logic        w_mem_we;
  logic [15:0] w_mem_addr;
  logic [15:0] w_mem_wdata;

  assign w_accept    = bus.req_valid && (r_state == IDLE);
  // 17-bit sum so an address near 0xFFFF cannot wrap into range.
  assign w_end_addr  = {1'b0, bus.req_addr} + {14'b0, bus.req_len};
  assign w_range_err = (w_end_addr > LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_mem_re    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    unique case (r_state)
      IDLE: begin
        if (w_accept && !w_range_err) w_next = bus.req_we ? WR : RD;
      end
      RD: begin
        w_mem_re   = 1'b1;
        w_mem_addr = r_cur_addr;
        if (r_count == '0) w_next = IDLE;
      end
      WR: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_cur_addr;
        w_mem_wdata = r_fill;
        if (r_count == '0) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Response registers default to zero every cycle so rsp_valid is a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_addr  <= '0;
      r_count     <= '0;
      r_fill      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cur_addr <= bus.req_addr;
            r_count    <= bus.req_len;
            r_fill     <= bus.req_wdata;
            if (w_range_err) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_last  <= 1'b1;
            end
          end
        end
        RD: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= bus.mem_rdata;
          r_rsp_last  <= (r_count == '0);
          r_cur_addr  <= r_cur_addr + 16'd1;
          r_count     <= r_count - 3'd1;
        end
        WR: begin
          r_cur_addr <= r_cur_addr + 16'd1;
          r_count    <= r_count - 3'd1;
          if (r_count == '0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_last  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready    = (r_state == IDLE);
  assign bus.busy         = (r_state != IDLE);
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = r_rsp_rdata;
  assign bus.rsp_last     = r_rsp_last;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.mem_read_en  = w_mem_re;
  assign bus.mem_write_en = w_mem_we;
  assign bus.mem_addr     = w_mem_addr;
  assign bus.mem_wdata    = w_mem_wdata;

endmodule
